fetch_queue: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register.
- Generates sequential fetch addresses and fetches words from a multi-cycle instruction memory over a req/ack handshake.
- Buffers fetched instructions with their PCs in a small FIFO.
- Presents the head entry to the decode stage with a valid/ready handshake. Flushes on branch/jump redirect from Ex.

---
 rtl/fetch_queue.sv | 113 +++++++++++
 tb/tb_fetch_queue.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential fetch over a req/ack memory port,
// a small PC+instruction FIFO, and a valid/ready head port toward decode.
//
// state | meaning
// IDLE  | no request outstanding; waits for a free slot
// WAIT  | request at fetch_pc outstanding; ack enqueues the word
// DROP  | request orphaned by a redirect; ack is consumed and discarded
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [31:0] out_pc,
   output logic [31:0] out_inst,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

   state_t        state;
   logic [31:0]   fetch_pc;
   logic [31:0]   drop_addr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [31:0]   pc_mem   [DEPTH];
   logic [31:0]   inst_mem [DEPTH];
   logic          enq;
   logic          deq;

   always_comb begin
      deq        = out_valid && out_ready && !redirect;
      enq        = (state == WAIT) && mem_ack && !redirect;
      count_next = count + CW'(enq) - CW'(deq);
   end

   assign out_valid = (count != '0);
   assign out_pc    = out_valid ? pc_mem[head]   : '0;
   assign out_inst  = out_valid ? inst_mem[head] : '0;
   assign mem_req   = (state != IDLE);
   // An orphaned request must keep its original address until it is acked.
   assign mem_addr  = (state == DROP) ? drop_addr : fetch_pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         fetch_pc  <= RESET_PC;
         drop_addr <= RESET_PC;
         count     <= '0;
         head      <= '0;
         tail      <= '0;
      end else begin
         if (redirect) begin
            fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
         end else begin
            count <= count_next;
            if (enq) begin
               tail     <= tail + PW'(1);
               fetch_pc <= fetch_pc + 32'd4;
            end
            if (deq) head <= head + PW'(1);
         end

         case (state)
            IDLE: begin
               if (!redirect && (count_next < CW'(DEPTH))) state <= WAIT;
            end
            WAIT: begin
               if (redirect) begin
                  if (mem_ack) begin
                     state <= IDLE;
                  end else begin
                     state     <= DROP;
                     drop_addr <= fetch_pc;
                  end
               end else if (mem_ack && (count_next >= CW'(DEPTH))) begin
                  state <= IDLE;
               end
            end
            DROP: begin
               if (mem_ack) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Storage needs no reset; count gates visibility of every slot.
   always_ff @(posedge clk) begin
      if (enq) begin
         pc_mem[tail]   <= fetch_pc;
         inst_mem[tail] <= mem_rdata;
      end
   end

   assert property (@(posedge clk) disable iff (rst) count <= CW'(DEPTH));

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a wait-state memory model answers requests with
// addr^A5A5_0000, and expected PCs are queued per scenario and popped on dequeue.
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        out_ready = 1'b0;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];

   bit          mem_en = 1'b1;
   int          wait_n = 0;
   bit          manual_mode = 1'b0;
   logic        manual_ack = 1'b0;
   logic [31:0] manual_rdata = '0;
   logic        model_ack = 1'b0;
   logic [31:0] model_rdata = '0;
   int          cnt = 0;

   assign mem_ack   = manual_mode ? manual_ack   : model_ack;
   assign mem_rdata = manual_mode ? manual_rdata : model_rdata;

   fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
      .out_ready(out_ready), .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Memory: acks after wait_n idle cycles of a held request.
   always begin
      @(negedge clk);
      #1;
      if (rst || !mem_req) begin
         cnt       = 0;
         model_ack = 1'b0;
      end else begin
         if (model_ack) cnt = 0;
         if (mem_en && cnt >= wait_n) begin
            model_ack   = 1'b1;
            model_rdata = mem_addr ^ 32'hA5A5_0000;
         end else begin
            model_ack = 1'b0;
            cnt++;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1);
   end

   task automatic do_reset();
      rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
      manual_mode = 1'b0; manual_ack = 1'b0; manual_rdata = '0;
      mem_en = 1'b1; wait_n = 0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      n_cmp++; if (out_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0", out_pc); end
      n_cmp++; if (out_inst !== 32'h0) begin n_err++; $display("FAIL reset_inst: got %h want 0", out_inst); end
      n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", mem_req); end
      n_cmp++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
   endtask

   task automatic test_stream();
      logic [31:0] e;
      out_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 11; i++) exp_q.push_back(32'(4 * i));
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         n_cmp++;
         if (out_valid !== 1'(k >= 2)) begin
            n_err++; $display("FAIL stream_valid: cycle %0d got %b want %b", k, out_valid, (k >= 2));
         end
         if (out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++; $display("FAIL stream_pop: unexpected pc=%h", out_pc);
            end else begin
               e = exp_q.pop_front();
               if ({out_pc, out_inst} !== {e, e ^ 32'hA5A5_0000}) begin
                  n_err++; $display("FAIL stream_data: got pc=%h inst=%h want pc=%h inst=%h", out_pc, out_inst, e, e ^ 32'hA5A5_0000);
               end
            end
         end
      end
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL stream_left: %0d entries not seen, want 0", exp_q.size()); end
   endtask

   task automatic test_fill();
      logic [31:0] e;
      out_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 6; i++) exp_q.push_back(32'(4 * i));
      for (int k = 1; k <= 13; k++) begin
         @(negedge clk);
         if (k == 6 || k == 7) begin
            n_cmp++;
            if ({mem_req, out_valid, out_pc} !== {1'b0, 1'b1, 32'h0}) begin
               n_err++; $display("FAIL fill_stop: cycle %0d got req=%b valid=%b pc=%h want req=0 valid=1 pc=0", k, mem_req, out_valid, out_pc);
            end
         end
         if (k == 8) out_ready = 1'b1;
         if (k >= 8) begin
            n_cmp++;
            if (out_valid !== 1'b1) begin n_err++; $display("FAIL fill_gap: cycle %0d got valid=%b want 1", k, out_valid); end
            if (out_valid && out_ready) begin
               n_cmp++;
               if (exp_q.size() == 0) begin
                  n_err++; $display("FAIL fill_pop: unexpected pc=%h", out_pc);
               end else begin
                  e = exp_q.pop_front();
                  if ({out_pc, out_inst} !== {e, e ^ 32'hA5A5_0000}) begin
                     n_err++; $display("FAIL fill_data: got pc=%h inst=%h want pc=%h inst=%h", out_pc, out_inst, e, e ^ 32'hA5A5_0000);
                  end
               end
            end
         end
      end
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL fill_left: %0d entries not seen, want 0", exp_q.size()); end
   endtask

   task automatic test_wait3();
      logic [31:0] e;
      logic [31:0] want_addr;
      out_ready = 1'b1;
      do_reset();
      wait_n = 3;
      exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         want_addr = 32'(4 * ((k - 1) / 4));
         n_cmp++;
         if ({mem_req, mem_addr} !== {1'b1, want_addr}) begin
            n_err++; $display("FAIL wait_addr: cycle %0d got req=%b addr=%h want req=1 addr=%h", k, mem_req, mem_addr, want_addr);
         end
         n_cmp++;
         if (out_valid !== 1'(k >= 5 && (k % 4) == 1)) begin
            n_err++; $display("FAIL wait_valid: cycle %0d got %b want %b", k, out_valid, (k >= 5 && (k % 4) == 1));
         end
         if (out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++; $display("FAIL wait_pop: unexpected pc=%h", out_pc);
            end else begin
               e = exp_q.pop_front();
               if ({out_pc, out_inst} !== {e, e ^ 32'hA5A5_0000}) begin
                  n_err++; $display("FAIL wait_data: got pc=%h inst=%h want pc=%h inst=%h", out_pc, out_inst, e, e ^ 32'hA5A5_0000);
               end
            end
         end
      end
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL wait_left: %0d entries not seen, want 0", exp_q.size()); end
   endtask

   task automatic test_redirect_drop();
      logic [31:0] e;
      out_ready = 1'b1;
      do_reset();
      exp_q.push_back(32'h0); exp_q.push_back(32'h4);
      exp_q.push_back(32'h100); exp_q.push_back(32'h104);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         case (k)
            3: begin
               n_cmp++;
               if (mem_addr !== 32'h8) begin n_err++; $display("FAIL drop_pre: got addr=%h want 8", mem_addr); end
               mem_en = 1'b0;
            end
            4: begin redirect = 1'b1; redirect_pc = 32'h100; end
            5, 6: begin
               redirect = 1'b0;
               n_cmp++;
               if ({mem_req, mem_addr, out_valid} !== {1'b1, 32'h8, 1'b0}) begin
                  n_err++; $display("FAIL drop_hold: cycle %0d got req=%b addr=%h valid=%b want req=1 addr=8 valid=0", k, mem_req, mem_addr, out_valid);
               end
               if (k == 6) mem_en = 1'b1;
            end
            7: begin
               n_cmp++;
               if ({mem_req, out_valid} !== 2'b00) begin
                  n_err++; $display("FAIL drop_done: got req=%b valid=%b want req=0 valid=0", mem_req, out_valid);
               end
            end
            8: begin
               n_cmp++;
               if ({mem_req, mem_addr} !== {1'b1, 32'h100}) begin
                  n_err++; $display("FAIL drop_restart: got req=%b addr=%h want req=1 addr=100", mem_req, mem_addr);
               end
            end
            default: ;
         endcase
         if (out_valid && out_ready && !redirect) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++; $display("FAIL drop_pop: unexpected pc=%h", out_pc);
            end else begin
               e = exp_q.pop_front();
               if ({out_pc, out_inst} !== {e, e ^ 32'hA5A5_0000}) begin
                  n_err++; $display("FAIL drop_data: got pc=%h inst=%h want pc=%h inst=%h", out_pc, out_inst, e, e ^ 32'hA5A5_0000);
               end
            end
         end
      end
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL drop_left: %0d entries not seen, want 0", exp_q.size()); end
   endtask

   task automatic test_redirect_deq();
      logic [31:0] e;
      out_ready = 1'b0;
      do_reset();
      exp_q.push_back(32'h200);
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         case (k)
            8: begin
               n_cmp++;
               if (out_valid !== 1'b1) begin n_err++; $display("FAIL rdq_pre: got valid=%b want 1", out_valid); end
               out_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h202;
            end
            9: begin
               redirect = 1'b0;
               n_cmp++;
               if ({out_valid, out_pc, out_inst, mem_req} !== {1'b0, 32'h0, 32'h0, 1'b0}) begin
                  n_err++; $display("FAIL rdq_flush: got valid=%b pc=%h inst=%h req=%b want 0/0/0/0", out_valid, out_pc, out_inst, mem_req);
               end
            end
            10: begin
               n_cmp++;
               if ({mem_req, mem_addr} !== {1'b1, 32'h200}) begin
                  n_err++; $display("FAIL rdq_addr: got req=%b addr=%h want req=1 addr=200", mem_req, mem_addr);
               end
            end
            default: ;
         endcase
         if (out_valid && out_ready && !redirect) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++; $display("FAIL rdq_pop: unexpected pc=%h", out_pc);
            end else begin
               e = exp_q.pop_front();
               if ({out_pc, out_inst} !== {e, e ^ 32'hA5A5_0000}) begin
                  n_err++; $display("FAIL rdq_data: got pc=%h inst=%h want pc=%h inst=%h", out_pc, out_inst, e, e ^ 32'hA5A5_0000);
               end
            end
         end
      end
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rdq_left: %0d entries not seen, want 0", exp_q.size()); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] e;
      bit found = 1'b0;
      out_ready = 1'b1;
      do_reset();
      for (int k = 0; k < 40 && !found; k++) begin
         @(negedge clk);
         if (mem_req && mem_addr == 32'h40) begin found = 1'b1; mem_en = 1'b0; end
      end
      n_cmp++; if (!found) begin n_err++; $display("FAIL rstm_reach: addr 40 not requested, got addr=%h", mem_addr); end
      @(negedge clk);
      n_cmp++;
      if ({mem_req, mem_addr} !== {1'b1, 32'h40}) begin
         n_err++; $display("FAIL rstm_wait: got req=%b addr=%h want req=1 addr=40", mem_req, mem_addr);
      end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({out_valid, out_pc, out_inst, mem_req, mem_addr} !== {1'b0, 32'h0, 32'h0, 1'b0, 32'h0}) begin
         n_err++; $display("FAIL rstm_async: got valid=%b pc=%h inst=%h req=%b addr=%h want all 0", out_valid, out_pc, out_inst, mem_req, mem_addr);
      end
      @(negedge clk);
      manual_mode = 1'b1; manual_ack = 1'b1; manual_rdata = 32'hDEAD_BEEF;
      rst = 1'b0;
      exp_q.delete();
      exp_q.push_back(32'h0);
      @(negedge clk);
      n_cmp++;
      if ({out_valid, mem_req, mem_addr} !== {1'b0, 1'b1, 32'h0}) begin
         n_err++; $display("FAIL rstm_ignore: got valid=%b req=%b addr=%h want valid=0 req=1 addr=0", out_valid, mem_req, mem_addr);
      end
      manual_mode = 1'b0; manual_ack = 1'b0; mem_en = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1) begin
         n_err++; $display("FAIL rstm_valid: got %b want 1", out_valid);
      end else begin
         e = exp_q.pop_front();
         n_cmp++;
         if ({out_pc, out_inst} !== {e, e ^ 32'hA5A5_0000}) begin
            n_err++; $display("FAIL rstm_data: got pc=%h inst=%h want pc=%h inst=%h", out_pc, out_inst, e, e ^ 32'hA5A5_0000);
         end
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_fill();
      test_wait3();
      test_redirect_drop();
      test_redirect_deq();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
